reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter CNT_W, default 2, meaning the width of the per-register pending-write counter; the saturation value is MAXC = 2^CNT_W-1.
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Clrn, input, 1 bit, reset; asynchronous, active-low.
REQ-004 SHALL have port Issue, input, 1 bit: the ID stage is attempting to issue an instruction this cycle.
REQ-005 SHALL have ports Rs and Rt, input, 5 bits each: source register numbers of the issuing instruction.
REQ-006 SHALL have ports UseRs and UseRt, input, 1 bit each: the instruction reads Rs or Rt.
REQ-007 SHALL have port Rd, input, 5 bits: destination register number, the value latched into the ID/EX destination flip-flops.
REQ-008 SHALL have port WReg, input, 1 bit: the issuing instruction writes Rd.
REQ-009 SHALL have port WbEn, input, 1 bit: the write-back stage commits a register write this cycle.
REQ-010 SHALL have port WbRd, input, 5 bits: register number being written back.
REQ-011 SHALL have port Stall, output, 1 bit, combinational: freeze PC/IF/ID and disable the ID/EX enable (En).
REQ-012 SHALL have port Busy, output, 32 bits: bit i = 1 when cnt[i] != 0.
REQ-013 SHALL have port Err, output, 1 bit, registered, sticky: write-back to a register with no pending write.

Function
REQ-014 SHALL hold one CNT_W-bit counter cnt[i] for each register i = 1..31; register 0 has no counter and is never busy.
REQ-015 Stall SHALL equal Issue AND (hazRs OR hazRt OR sat).
- hazRs = UseRs & Rs != 0 & cnt[Rs] != 0
- hazRt = UseRt & Rt != 0 & cnt[Rt] != 0
- sat = WReg & Rd != 0 & cnt[Rd] == MAXC
REQ-016 Stall SHALL use only registered counter values; a same-cycle write-back to Rs/Rt SHALL NOT clear the stall (no bypass), so release comes on the next cycle.
REQ-017 An accepted issue is Issue & !Stall & WReg & Rd != 0; it SHALL increment cnt[Rd] by 1 at the clock edge.
REQ-018 A valid write-back is WbEn & WbRd != 0 & cnt[WbRd] != 0; it SHALL decrement cnt[WbRd] by 1 at the clock edge.
REQ-019 If an accepted issue and a valid write-back target the same register in one cycle, that counter SHALL be unchanged.
REQ-020 If an accepted issue and a valid write-back target different registers in one cycle, both updates SHALL occur at that edge.
REQ-021 WbEn with WbRd != 0 and cnt[WbRd] == 0 SHALL leave all counters unchanged and set Err to 1 at the next edge.
- Err SHALL remain 1 until reset.
REQ-022 WbEn with WbRd == 0 SHALL be ignored and SHALL NOT set Err.
REQ-023 Counters SHALL never wrap: no increment at MAXC (prevented by sat) and no decrement at 0.
REQ-024 Busy SHALL reflect registered counter state, updated one edge after the causing event.
REQ-025 Issue = 0 SHALL force Stall = 0 regardless of the other inputs.

Reset
REQ-026 Clrn = 0 SHALL immediately, without waiting for Clk, force all counters to 0, Busy to 32'h0 and Err to 0.
- With Issue = 0, Stall reads 0 during reset.
REQ-027 Reset asserted mid-operation SHALL discard all pending state; write-backs arriving after release for pre-reset issues SHALL set Err per REQ-021.
REQ-028 The first rising Clk edge after Clrn rises SHALL perform normal updates.

Verification
REQ-029 Issue Rd=5, WReg=1 -> Busy[5]=1 the next cycle; then Issue UseRs=1, Rs=5 -> Stall=1; WbEn, WbRd=5 -> Stall=0 one cycle later, Busy[5]=0.
REQ-030 Issue Rd=0, WReg=1 -> Busy=0, Stall=0 throughout; a dependent read with Rs=0 -> Stall=0.
REQ-031 With CNT_W=2, three accepted issues to Rd=7 -> cnt=3; a fourth issue to Rd=7 -> Stall=1 and cnt stays 3; one write-back to 7 -> the issue is accepted the next cycle.
REQ-032 With cnt[9]=1, a same-cycle accepted issue to Rd=9 and WbRd=9 -> cnt[9] stays 1 and Busy[9] stays 1.
REQ-033 WbEn, WbRd=12 with cnt[12]=0 -> Err=1 the next cycle and stays 1; WbRd=0 alone -> Err unaffected.
REQ-034 Busy=32'h0000_0420 with Clrn pulsed low between edges -> Busy=0 and Err=0 asynchronously, before the next Clk edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters that stall issue on
// read-after-write hazards or when the destination counter is saturated.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        Issue,
    input  logic [4:0]  Rs,
    input  logic [4:0]  Rt,
    input  logic        UseRs,
    input  logic        UseRt,
    input  logic [4:0]  Rd,
    input  logic        WReg,
    input  logic        WbEn,
    input  logic [4:0]  WbRd,
    output logic        Stall,
    output logic [31:0] Busy,
    output logic        Err
);
    localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};
    logic [CNT_W-1:0] r_cnt [32];
    logic             r_err;
    logic             w_haz_rs, w_haz_rt, w_sat, w_inc, w_dec, w_bad_wb;
    // Entry 0 is never incremented, so it stays zero and register 0 is never busy.
    assign w_haz_rs = UseRs && Rs != '0 && r_cnt[Rs] != '0;
    assign w_haz_rt = UseRt && Rt != '0 && r_cnt[Rt] != '0;
    assign w_sat    = WReg && Rd != '0 && r_cnt[Rd] == MAXC;
    assign Stall    = Issue && (w_haz_rs || w_haz_rt || w_sat);
    assign w_inc    = Issue && !Stall && WReg && Rd != '0;
    assign w_dec    = WbEn && WbRd != '0 && r_cnt[WbRd] != '0;
    assign w_bad_wb = WbEn && WbRd != '0 && r_cnt[WbRd] == '0;
    assign Err      = r_err;
    always_comb
        for (int i = 0; i < 32; i++) Busy[i] = r_cnt[i] != '0;
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_inc && Rd == 5'(i) && !(w_dec && WbRd == 5'(i)))
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                else if (w_dec && WbRd == 5'(i) && !(w_inc && Rd == 5'(i)))
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
            end
            r_err <= r_err | w_bad_wb;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and random stimulus against a counting reference
// model; expectations are queued by the driver and checked by a monitor.
module tb_reg_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
    typedef struct {
        logic        stall;
        logic [31:0] busy;
        logic        err;
    } exp_t;
    logic        Clk = 1'b0, Clrn = 1'b0;
    logic        Issue = 0, UseRs = 0, UseRt = 0, WReg = 0, WbEn = 0;
    logic [4:0]  Rs = 0, Rt = 0, Rd = 0, WbRd = 0;
    logic        Stall, Err;
    logic [31:0] Busy;
    exp_t        q[$];
    int          m_cnt[32];
    bit          m_err;
    int          checks = 0, errors = 0;

    reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .Clk(Clk), .Clrn(Clrn), .Issue(Issue), .Rs(Rs), .Rt(Rt),
        .UseRs(UseRs), .UseRt(UseRt), .Rd(Rd), .WReg(WReg),
        .WbEn(WbEn), .WbRd(WbRd), .Stall(Stall), .Busy(Busy), .Err(Err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = m_cnt[i] > 0;
        return b;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 0;
    endfunction

    // Drive one cycle, queue what the DUT must show this cycle, then advance the model.
    task automatic step(input bit iss, input bit urs, input logic [4:0] rs,
                        input bit urt, input logic [4:0] rt, input bit wr,
                        input logic [4:0] rd, input bit wb, input logic [4:0] wrd);
        exp_t e;
        bit   acc, dec;
        @(negedge Clk);
        Issue = iss; UseRs = urs; Rs = rs; UseRt = urt; Rt = rt;
        WReg = wr; Rd = rd; WbEn = wb; WbRd = wrd;
        e.stall = iss && ((urs && rs != 0 && m_cnt[rs] > 0) ||
                          (urt && rt != 0 && m_cnt[rt] > 0) ||
                          (wr && rd != 0 && m_cnt[rd] == MAXC));
        e.busy  = m_busy();
        e.err   = m_err;
        q.push_back(e);
        acc = iss && !e.stall && wr && rd != 0;
        dec = wb && wrd != 0 && m_cnt[wrd] > 0;
        if (wb && wrd != 0 && m_cnt[wrd] == 0) m_err = 1;
        if (acc) m_cnt[rd]++;
        if (dec) m_cnt[wrd]--;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Pulse reset between edges and require cleared outputs before any clock edge.
    task automatic async_reset();
        @(posedge Clk);
        #1;
        Issue = 0; WbEn = 0; WReg = 0; UseRs = 0; UseRt = 0;
        #1 Clrn = 0;
        #1;
        check("rst_busy", Busy, 32'h0);
        check("rst_err", {31'h0, Err}, 32'h0);
        check("rst_stall", {31'h0, Stall}, 32'h0);
        m_reset();
        #1 Clrn = 1;
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("stall", {31'h0, Stall}, {31'h0, e.stall});
                check("busy", Busy, e.busy);
                check("err", {31'h0, Err}, {31'h0, e.err});
            end
        end
    end

    initial begin : driver
        m_reset();
        #12 Clrn = 1;
        idle();
        // basic RAW hazard and release one cycle after write-back
        step(1, 0, 0, 0, 0, 1, 5, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 1, 5);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0);
        // register 0 is never tracked
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0);
        // saturation on Rd=7
        repeat (3) step(1, 0, 0, 0, 0, 1, 7, 0, 0);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0);
        step(1, 0, 0, 0, 0, 1, 7, 1, 7);
        step(1, 0, 0, 0, 0, 1, 7, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 7);
        // simultaneous issue and write-back to the same register
        step(1, 0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 0, 0, 0, 0, 1, 9, 1, 9);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9);
        // different registers in the same cycle
        step(1, 0, 0, 0, 0, 1, 3, 0, 0);
        step(1, 0, 0, 1, 4, 1, 6, 1, 3);
        idle();
        // zero-register write-back is ignored, then unmatched write-back is sticky
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 12);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        // async reset while registers 5 and 10 are busy
        step(1, 0, 0, 0, 0, 1, 5, 0, 0);
        step(1, 0, 0, 0, 0, 1, 10, 0, 0);
        idle();
        async_reset();
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 5);
        idle();
        async_reset();
        // random traffic concentrated on a few registers
        for (int n = 0; n < 800; n++) begin
            if (n % 200 == 199) async_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1), pick(),
                 $urandom_range(0, 1), pick(), $urandom_range(0, 3) != 0, pick(),
                 $urandom_range(0, 9) < 4, pick());
        end
        idle();
        @(negedge Clk);
        #3;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
